enc_snapshot_ctrl: RTL

Snapshot and readout controller for the per-channel encoder period/acceleration datapath. On a host request it atomically captures `period`, `acc` and `t_cur` from all encoder channels into a shadow buffer, so one block read returns a coherent set of values. It serves word reads from that buffer over a single-cycle request/acknowledge port and tracks per-channel staleness. It sits between the encoder period modules and the board's register read mux.

---
 rtl/enc_snapshot_ctrl_pkg.sv | 31 +++
 rtl/enc_snapshot_ctrl_if.sv | 32 +++
 rtl/enc_snapshot_ctrl_stale_cnt.sv | 49 ++++
 rtl/enc_snapshot_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/enc_snapshot_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// enc_snap_pkg
// Shared definitions for the encoder snapshot/readout controller:
//   - read-select codes for the low two bits of the read address
//   - controller state encoding
//   - stale-counter saturation value and status-word packing helper
// Optional feature macro used by the block: ENC_SNAP_STALE_EN
// ---------------------------------------------------------------------------
package enc_snap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } snap_state_e;

    localparam logic [1:0] SEL_PERIOD = 2'd0;
    localparam logic [1:0] SEL_ACC    = 2'd1;
    localparam logic [1:0] SEL_TCUR   = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    localparam logic [7:0] STALE_MAX  = 8'hFF;

    // flags = buffered period[31:30] (overflow, dir)
    function automatic logic [31:0] status_word(input logic [1:0] flags,
                                                input logic [7:0] stale,
                                                input logic [7:0] seq);
        return {flags, 14'd0, stale, seq};
    endfunction

endpackage

// File: rtl/enc_snapshot_ctrl_if.sv
// ---------------------------------------------------------------------------
// enc_snap_if
// Host-side handshake bundle of the snapshot controller.
//   snap_req  : snapshot request level (master -> slave)
//   snap_busy : controller not idle     (slave -> master)
//   snap_done : one-cycle capture-complete pulse
//   rd_req    : read strobe, rd_addr = {channel, sel}
//   rd_ack    : one-cycle read acknowledge, rd_data valid with it
//   rd_data   : read data, held until the next acknowledge
// Modports: master (host / register mux), slave (controller).
// ---------------------------------------------------------------------------
interface enc_snap_if #(
    parameter int CH_BITS = 2
) ();
    logic               snap_req;
    logic               snap_busy;
    logic               snap_done;
    logic               rd_req;
    logic [CH_BITS+1:0] rd_addr;
    logic               rd_ack;
    logic [31:0]        rd_data;

    modport master (
        output snap_req, rd_req, rd_addr,
        input  snap_busy, snap_done, rd_ack, rd_data
    );

    modport slave (
        input  snap_req, rd_req, rd_addr,
        output snap_busy, snap_done, rd_ack, rd_data
    );
endinterface

// File: rtl/enc_snapshot_ctrl_stale_cnt.sv
// ---------------------------------------------------------------------------
// enc_stale_cnt
// Per-channel staleness counter. On each capture strobe the count
// increments (saturating at STALE_MAX) when the new period[21:0] equals the
// buffered one, otherwise it clears. Only instantiated when
// ENC_SNAP_STALE_EN is defined.
// Ports:
//   clk, reset   : clock, synchronous active-low reset
//   cap_i        : capture strobe (controller in CAPTURE)
//   new_per_i    : incoming period[21:0]
//   old_per_i    : buffered period[21:0]
//   cnt_o        : 8-bit saturating stale count
// ---------------------------------------------------------------------------
module enc_stale_cnt
    import enc_snap_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cap_i,
    input  logic [21:0] new_per_i,
    input  logic [21:0] old_per_i,
    output logic [7:0]  cnt_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cap_i) begin
            if (new_per_i == old_per_i) begin
                cnt_d = (cnt_q == STALE_MAX) ? cnt_q : cnt_q + 8'd1;
            end else begin
                cnt_d = 8'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/enc_snapshot_ctrl.sv
// ---------------------------------------------------------------------------
// enc_snapshot_ctrl
// Atomically captures period/acc/t_cur of all encoder channels into a
// shadow buffer on host request and serves single-cycle word reads from it.
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   period_in/acc_in/tcur_in : 32*NUM_ENC concatenated channel words
//   bus (enc_snap_if.slave)  : snapshot handshake and read port
// Read address = {channel, sel}; sel 0 period, 1 acc, 2 t_cur, 3 status.
// Status = {ovf, dir, 14'b0, stale[7:0], seq[7:0]}.
// Optional feature: ENC_SNAP_STALE_EN enables the per-channel stale
// counters; without it status[15:8] reads 0.
// ---------------------------------------------------------------------------
module enc_snapshot_ctrl
    import enc_snap_pkg::*;
#(
    parameter int NUM_ENC = 4,
    parameter int CH_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [32*NUM_ENC-1:0] period_in,
    input  logic [32*NUM_ENC-1:0] acc_in,
    input  logic [32*NUM_ENC-1:0] tcur_in,
    enc_snap_if.slave            bus
);

    snap_state_e state_q;
    logic        pending_q;
    logic [7:0]  seq_q;
    logic        busy_q;
    logic        done_q;

    logic [31:0] period_q [NUM_ENC];
    logic [31:0] acc_q    [NUM_ENC];
    logic [31:0] tcur_q   [NUM_ENC];
    logic [7:0]  stale    [NUM_ENC];

    logic        rd_ack_q;
    logic [31:0] rd_data_q;
    logic [31:0] rd_data_d;

    logic [CH_BITS-1:0] rd_ch;
    logic [1:0]         rd_sel;

    logic cap;
    assign cap = (state_q == ST_CAPTURE);

    // Control FSM; busy/done are registered so they line up with state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            seq_q     <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.snap_req) begin
                        state_q <= ST_CAPTURE;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    seq_q   <= seq_q + 8'd1;
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                    if (bus.snap_req) begin
                        pending_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // A request seen now collapses into the same single
                    // pending slot as one seen during CAPTURE.
                    if (pending_q || bus.snap_req) begin
                        state_q   <= ST_CAPTURE;
                        pending_q <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Shadow buffer: loaded at the edge that ends the CAPTURE cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NUM_ENC; k++) begin
                period_q[k] <= 32'd0;
                acc_q[k]    <= 32'd0;
                tcur_q[k]   <= 32'd0;
            end
        end else if (cap) begin
            for (int k = 0; k < NUM_ENC; k++) begin
                period_q[k] <= period_in[32*k +: 32];
                acc_q[k]    <= acc_in[32*k +: 32];
                tcur_q[k]   <= tcur_in[32*k +: 32];
            end
        end
    end

`ifdef ENC_SNAP_STALE_EN
    for (genvar k = 0; k < NUM_ENC; k++) begin : g_stale
        enc_stale_cnt u_stale (
            .clk       (clk),
            .reset     (reset),
            .cap_i     (cap),
            .new_per_i (period_in[32*k +: 22]),
            .old_per_i (period_q[k][21:0]),
            .cnt_o     (stale[k])
        );
    end
`else
    for (genvar k = 0; k < NUM_ENC; k++) begin : g_stale
        assign stale[k] = 8'd0;
    end
`endif

    assign rd_ch  = bus.rd_addr[CH_BITS+1:2];
    assign rd_sel = bus.rd_addr[1:0];

    // Unpopulated channel indices match no k and read as zero.
    always_comb begin
        rd_data_d = 32'd0;
        for (int k = 0; k < NUM_ENC; k++) begin
            if (rd_ch == CH_BITS'(k)) begin
                case (rd_sel)
                    SEL_PERIOD: rd_data_d = period_q[k];
                    SEL_ACC:    rd_data_d = acc_q[k];
                    SEL_TCUR:   rd_data_d = tcur_q[k];
                    SEL_STATUS: rd_data_d = status_word(period_q[k][31:30],
                                                        stale[k], seq_q);
                    default:    rd_data_d = 32'd0;
                endcase
            end
        end
    end

    // Read port samples the buffer before any same-edge capture update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ack_q  <= 1'b0;
            rd_data_q <= 32'd0;
        end else begin
            rd_ack_q <= bus.rd_req;
            if (bus.rd_req) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    assign bus.snap_busy = busy_q;
    assign bus.snap_done = done_q;
    assign bus.rd_ack    = rd_ack_q;
    assign bus.rd_data   = rd_data_q;

endmodule
